bus_responder: RTL and testbench
================================

BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 The block SHALL have parameter BASE_HI, default 4'h0: addr[15:12] value that selects this responder's 4 KiB window.
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 10: log2 of storage bytes; legal range 1..12.
REQ-003 The block SHALL have parameter WAIT, default 2: wait states per access; legal range 0..15.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state changes on posedge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high; clock clk.
REQ-006 The block SHALL have port req, input, 1 bit: CPU bus cycle valid (address/rw/wdata stable).
REQ-007 The block SHALL have port addr, input, 16 bits: CPU address.
REQ-008 The block SHALL have port rw, input, 1 bit: 1 = read, 0 = write (6502 convention).
REQ-009 The block SHALL have port wdata, input, 8 bits: CPU write data.
REQ-010 The block SHALL have port rdata, output, 8 bits: read data toward the CPU data bus.
REQ-011 The block SHALL have port drive_en, output, 1 bit: enable for the external data-bus tristate; high only while rdata is valid.
REQ-012 The block SHALL have port rdy, output, 1 bit: CPU ready; 0 stalls the CPU.
REQ-013 The block SHALL have port hit, output, 1 bit: combinational decode, req & (addr[15:12] == BASE_HI).

Function
REQ-014 The storage SHALL be a 2^DEPTH_LOG2 x 8 array indexed by addr[DEPTH_LOG2-1:0]; higher window bits alias.
REQ-015 The FSM SHALL have states IDLE, WAITING, DONE, all with registered outputs.
REQ-016 Acceptance SHALL occur at a posedge in IDLE or DONE with hit=1: capture addr index, rw and wdata into holding registers.
REQ-017 On acceptance with WAIT=0, the next state SHALL be DONE.
REQ-018 On acceptance with WAIT>0, the next state SHALL be WAITING, with a 4-bit counter loaded to WAIT-1 and rdy forced to 0.
REQ-019 In WAITING, rdy SHALL be 0 and drive_en 0; the counter decrements each posedge; at a posedge with counter=0 the next state is DONE.
REQ-020 For a request accepted at edge k, DONE SHALL be entered at edge k+WAIT; rdy is 0 for exactly WAIT cycles.
REQ-021 Write commit: at the edge entering DONE with captured rw=0, mem[index] SHALL be written with captured wdata; drive_en stays 0.
REQ-022 Read: at the edge entering DONE with captured rw=1, rdata SHALL load mem[index] and drive_en shall be set to 1, both for exactly the DONE cycle.
REQ-023 In DONE, rdy SHALL be 1.
REQ-024 From DONE, with hit=1 the block SHALL accept back-to-back (REQ-016..018); otherwise it returns to IDLE.
REQ-025 A read accepted in DONE after a write to the same index SHALL return the newly written value.
REQ-026 In IDLE, rdy SHALL be 1, drive_en 0 and rdata 8'h00.
REQ-027 req with hit=0 SHALL be ignored: no state change, rdy stays 1, no drive, no memory write.
REQ-028 Inputs SHALL be sampled only at acceptance; changes to addr/rw/wdata during WAITING SHALL have no effect.
REQ-029 Whenever drive_en=0, rdata SHALL be 8'h00.

Reset
REQ-030 When reset=1 at a posedge, the next state SHALL be IDLE with rdy=1, drive_en=0, rdata=8'h00, counter=0 and holding registers=0.
REQ-031 Reset SHALL override acceptance, including mid-transaction in WAITING or DONE.
REQ-032 A write pending in WAITING SHALL be dropped by reset and never committed.
REQ-033 Storage contents SHALL NOT be cleared by reset; contents are undefined until written.

Verification
REQ-034 Bench SHALL cover: WAIT=2, BASE_HI=0; write addr 16'h0012 data 8'hA5 at edge k -> rdy 0 for cycles k..k+1, rdy 1 at k+2, drive_en stays 0.
REQ-035 Bench SHALL cover: then read 16'h0012 -> rdy low 2 cycles, then a single cycle with drive_en=1, rdata=8'hA5, rdy=1; afterwards rdata=8'h00.
REQ-036 Bench SHALL cover: WAIT=0; write 16'h0412 data 8'h3C in DONE, followed back-to-back by a read of 16'h0012 -> aliased read returns 8'h3C one cycle after acceptance, rdy never 0.
REQ-037 Bench SHALL cover: req with addr 16'h2000 (BASE_HI=0) -> hit=0, rdy stays 1, drive_en 0, memory unchanged on later read.
REQ-038 Bench SHALL cover: WAIT=3; write 16'h0005 data 8'hFF, reset asserted during the second WAITING cycle -> IDLE, rdy=1; a later read of 16'h0005 returns the prior value (8'h00 pre-written), not 8'hFF.
REQ-039 Bench SHALL cover: WAIT=2; addr/wdata changed during WAITING -> the originally captured address/data are used.

Source files
------------

// File: rtl/bus_responder.sv
// Memory-backed CPU bus responder with a 4 KiB decode window and a fixed
// number of wait states; read data is driven for exactly one cycle.
module bus_responder #(
    parameter logic [3:0]  BASE_HI    = 4'h0,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned WAIT       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [15:0] addr,
    input  logic        rw,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        drive_en,
    output logic        rdy,
    output logic        hit
);

    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam int unsigned AW        = DEPTH_LOG2;
    localparam logic [3:0]  WAIT_LOAD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITING = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [3:0]      cnt;
    logic [3:0]      cnt_nx;
    logic [AW-1:0]   idx_q;
    logic [AW-1:0]   idx_nx;
    logic            rw_q;
    logic            rw_nx;
    logic [7:0]      wdata_q;
    logic [7:0]      wdata_nx;

    // Transaction that completes at the coming edge (held or, with no waits, live)
    logic            enter_done;
    logic [AW-1:0]   eff_idx;
    logic            eff_rw;
    logic [7:0]      eff_wdata;

    logic            rdy_nx;
    logic            drive_en_nx;
    logic [7:0]      rdata_nx;
    logic            accept;
    logic            unused_addr;

    logic [7:0]      mem [DEPTH];

    assign hit         = req && (addr[15:12] == BASE_HI);
    assign accept      = ((state == IDLE) || (state == DONE)) && hit;
    assign unused_addr = ^addr[11:0];

    // State, counter, holding and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            idx_q    <= '0;
            rw_q     <= 1'b0;
            wdata_q  <= 8'h00;
            rdy      <= 1'b1;
            drive_en <= 1'b0;
            rdata    <= 8'h00;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            idx_q    <= idx_nx;
            rw_q     <= rw_nx;
            wdata_q  <= wdata_nx;
            rdy      <= rdy_nx;
            drive_en <= drive_en_nx;
            rdata    <= rdata_nx;
        end
    end

    // Next-state, capture and completion decode
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        idx_nx     = idx_q;
        rw_nx      = rw_q;
        wdata_nx   = wdata_q;
        enter_done = 1'b0;
        eff_idx    = idx_q;
        eff_rw     = rw_q;
        eff_wdata  = wdata_q;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    idx_nx   = addr[AW-1:0];
                    rw_nx    = rw;
                    wdata_nx = wdata;
                    if (WAIT == 0) begin
                        state_nx   = DONE;
                        enter_done = 1'b1;
                        eff_idx    = addr[AW-1:0];
                        eff_rw     = rw;
                        eff_wdata  = wdata;
                    end else begin
                        state_nx = WAITING;
                        cnt_nx   = WAIT_LOAD;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            WAITING: begin
                if (cnt == 4'd0) begin
                    state_nx   = DONE;
                    enter_done = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Registered-output next values
    always_comb begin
        rdy_nx      = 1'b1;
        drive_en_nx = 1'b0;
        rdata_nx    = 8'h00;
        if (state_nx == WAITING) begin
            rdy_nx = 1'b0;
        end
        if (enter_done && eff_rw) begin
            drive_en_nx = 1'b1;
            rdata_nx    = mem[eff_idx];
        end
    end

    // Storage is never cleared; a pending write is dropped when reset wins
    always_ff @(posedge clk) begin
        if (!reset && enter_done && !eff_rw) begin
            mem[eff_idx] <= eff_wdata;
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: three instances (WAIT=2, WAIT=0, WAIT=3)
// driven from a vector table plus hand-written reset/wait sequences.
module tb_bus_responder;

    logic        clk = 1'b0;
    logic        rst2, rst0, rst3;
    logic        req2, req0, req3;
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wdata;

    logic [7:0]  rdata2, rdata0, rdata3;
    logic        de2, de0, de3;
    logic        rdy2, rdy0, rdy3;
    logic        hit2, hit0, hit3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bus_responder #(.BASE_HI(4'h0), .DEPTH_LOG2(10), .WAIT(2)) u2 (
        .clk(clk), .reset(rst2), .req(req2), .addr(addr), .rw(rw), .wdata(wdata),
        .rdata(rdata2), .drive_en(de2), .rdy(rdy2), .hit(hit2));

    bus_responder #(.BASE_HI(4'h0), .DEPTH_LOG2(10), .WAIT(0)) u0 (
        .clk(clk), .reset(rst0), .req(req0), .addr(addr), .rw(rw), .wdata(wdata),
        .rdata(rdata0), .drive_en(de0), .rdy(rdy0), .hit(hit0));

    bus_responder #(.BASE_HI(4'h0), .DEPTH_LOG2(10), .WAIT(3)) u3 (
        .clk(clk), .reset(rst3), .req(req3), .addr(addr), .rw(rw), .wdata(wdata),
        .rdata(rdata3), .drive_en(de3), .rdy(rdy3), .hit(hit3));

    typedef struct {
        int          sel;
        logic        rq;
        logic [15:0] a;
        logic        r;
        logic [7:0]  wd;
        logic        e_hit;
        logic        e_rdy;
        logic        e_de;
        logic [7:0]  e_rd;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input int sel, input logic rq, input logic [15:0] a,
                                input logic r, input logic [7:0] wd, input logic e_hit,
                                input logic e_rdy, input logic e_de, input logic [7:0] e_rd);
        vec_t v;
        v.sel = sel; v.rq = rq; v.a = a; v.r = r; v.wd = wd;
        v.e_hit = e_hit; v.e_rdy = e_rdy; v.e_de = e_de; v.e_rd = e_rd;
        return v;
    endfunction

    // Drive one bus cycle to the selected instance, checking hit before the edge
    task automatic apply(input int sel, input logic rq, input logic [15:0] a,
                         input logic r, input logic [7:0] wd, input logic e_hit);
        logic h;
        @(negedge clk);
        req2  = (sel == 0) ? rq : 1'b0;
        req0  = (sel == 1) ? rq : 1'b0;
        req3  = (sel == 2) ? rq : 1'b0;
        addr  = a;
        rw    = r;
        wdata = wd;
        #1;
        h = (sel == 0) ? hit2 : (sel == 1) ? hit0 : hit3;
        tests++;
        if (h !== e_hit) begin
            fails++;
            $display("FAIL hit dut%0d addr=%h: got %b expected %b", sel, a, h, e_hit);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input int sel, input string tag, input logic e_rdy,
                             input logic e_de, input logic [7:0] e_rd);
        logic       ry, de;
        logic [7:0] rd;
        ry = (sel == 0) ? rdy2   : (sel == 1) ? rdy0   : rdy3;
        de = (sel == 0) ? de2    : (sel == 1) ? de0    : de3;
        rd = (sel == 0) ? rdata2 : (sel == 1) ? rdata0 : rdata3;
        tests++;
        if (ry !== e_rdy || de !== e_de || rd !== e_rd) begin
            fails++;
            $display("FAIL %s dut%0d: got rdy=%b drive_en=%b rdata=%h expected rdy=%b drive_en=%b rdata=%h",
                     tag, sel, ry, de, rd, e_rdy, e_de, e_rd);
        end
    endtask

    initial begin
        // sel 0: WAIT=2 instance
        vq.push_back(mk(0, 1, 16'h0012, 0, 8'hA5, 1, 0, 0, 8'h00));
        vq.push_back(mk(0, 0, 16'h0012, 0, 8'hA5, 0, 0, 0, 8'h00));
        vq.push_back(mk(0, 0, 16'h0000, 1, 8'h00, 0, 1, 0, 8'h00));
        vq.push_back(mk(0, 1, 16'h0012, 1, 8'h00, 1, 0, 0, 8'h00));
        vq.push_back(mk(0, 0, 16'h0012, 1, 8'h00, 0, 0, 0, 8'h00));
        vq.push_back(mk(0, 0, 16'h0012, 1, 8'h00, 0, 1, 1, 8'hA5));
        vq.push_back(mk(0, 0, 16'h0012, 1, 8'h00, 0, 1, 0, 8'h00));
        vq.push_back(mk(0, 1, 16'h2000, 0, 8'h77, 0, 1, 0, 8'h00));
        vq.push_back(mk(0, 1, 16'h2012, 0, 8'h77, 0, 1, 0, 8'h00));
        vq.push_back(mk(0, 1, 16'h0012, 1, 8'h00, 1, 0, 0, 8'h00));
        vq.push_back(mk(0, 0, 16'h0012, 1, 8'h00, 0, 0, 0, 8'h00));
        vq.push_back(mk(0, 0, 16'h0012, 1, 8'h00, 0, 1, 1, 8'hA5));
        vq.push_back(mk(0, 0, 16'h0012, 1, 8'h00, 0, 1, 0, 8'h00));
        vq.push_back(mk(0, 1, 16'h0034, 0, 8'h5A, 1, 0, 0, 8'h00));
        vq.push_back(mk(0, 1, 16'h0035, 1, 8'hFF, 1, 0, 0, 8'h00));
        vq.push_back(mk(0, 0, 16'h0035, 0, 8'hFF, 0, 1, 0, 8'h00));
        vq.push_back(mk(0, 1, 16'h0034, 1, 8'h00, 1, 0, 0, 8'h00));
        vq.push_back(mk(0, 0, 16'h0034, 1, 8'h00, 0, 0, 0, 8'h00));
        vq.push_back(mk(0, 0, 16'h0034, 1, 8'h00, 0, 1, 1, 8'h5A));
        vq.push_back(mk(0, 0, 16'h0034, 1, 8'h00, 0, 1, 0, 8'h00));
        // sel 1: WAIT=0 instance, back-to-back in DONE and window aliasing
        vq.push_back(mk(1, 1, 16'h0012, 0, 8'h11, 1, 1, 0, 8'h00));
        vq.push_back(mk(1, 1, 16'h0412, 0, 8'h3C, 1, 1, 0, 8'h00));
        vq.push_back(mk(1, 1, 16'h0012, 1, 8'h00, 1, 1, 1, 8'h3C));
        vq.push_back(mk(1, 0, 16'h0012, 1, 8'h00, 0, 1, 0, 8'h00));
        vq.push_back(mk(1, 1, 16'h2012, 1, 8'h00, 0, 1, 0, 8'h00));
        vq.push_back(mk(1, 1, 16'h0812, 1, 8'h00, 1, 1, 1, 8'h3C));
        vq.push_back(mk(1, 0, 16'h0812, 1, 8'h00, 0, 1, 0, 8'h00));

        rst2 = 1'b1; rst0 = 1'b1; rst3 = 1'b1;
        req2 = 1'b0; req0 = 1'b0; req3 = 1'b0;
        addr = 16'h0000; rw = 1'b1; wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_out(0, "reset", 1, 0, 8'h00);
        check_out(1, "reset", 1, 0, 8'h00);
        check_out(2, "reset", 1, 0, 8'h00);
        @(negedge clk);
        rst2 = 1'b0; rst0 = 1'b0; rst3 = 1'b0;

        foreach (vq[i]) begin
            string tag;
            apply(vq[i].sel, vq[i].rq, vq[i].a, vq[i].r, vq[i].wd, vq[i].e_hit);
            tag = $sformatf("vec%0d", i);
            check_out(vq[i].sel, tag, vq[i].e_rdy, vq[i].e_de, vq[i].e_rd);
        end

        // WAIT=3: pre-write 0x00 to 0x0005, rdy low for exactly three cycles
        apply(2, 1, 16'h0005, 0, 8'h00, 1);
        check_out(2, "pre_w0", 0, 0, 8'h00);
        apply(2, 0, 16'h0005, 0, 8'h00, 0);
        check_out(2, "pre_w1", 0, 0, 8'h00);
        apply(2, 0, 16'h0005, 0, 8'h00, 0);
        check_out(2, "pre_w2", 0, 0, 8'h00);
        apply(2, 0, 16'h0005, 0, 8'h00, 0);
        check_out(2, "pre_done", 1, 0, 8'h00);
        apply(2, 0, 16'h0005, 0, 8'h00, 0);
        check_out(2, "pre_idle", 1, 0, 8'h00);

        // Write 0xFF, then reset during the second WAITING cycle drops it
        apply(2, 1, 16'h0005, 0, 8'hFF, 1);
        check_out(2, "drop_w0", 0, 0, 8'h00);
        apply(2, 0, 16'h0005, 0, 8'hFF, 0);
        check_out(2, "drop_w1", 0, 0, 8'h00);
        rst3 = 1'b1;
        apply(2, 0, 16'h0005, 0, 8'hFF, 0);
        check_out(2, "drop_reset", 1, 0, 8'h00);
        rst3 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            apply(2, 0, 16'h0005, 0, 8'hFF, 0);
            check_out(2, $sformatf("drop_idle%0d", c), 1, 0, 8'h00);
        end

        // Read back: the dropped write must not be visible
        apply(2, 1, 16'h0005, 1, 8'h00, 1);
        check_out(2, "rb_w0", 0, 0, 8'h00);
        apply(2, 0, 16'h0005, 1, 8'h00, 0);
        check_out(2, "rb_w1", 0, 0, 8'h00);
        apply(2, 0, 16'h0005, 1, 8'h00, 0);
        check_out(2, "rb_w2", 0, 0, 8'h00);
        apply(2, 0, 16'h0005, 1, 8'h00, 0);
        check_out(2, "rb_done", 1, 1, 8'h00);
        apply(2, 0, 16'h0005, 1, 8'h00, 0);
        check_out(2, "rb_idle", 1, 0, 8'h00);

        // Reset overrides acceptance of a hitting request
        rst3 = 1'b1;
        apply(2, 1, 16'h0005, 1, 8'h00, 1);
        check_out(2, "rst_vs_accept", 1, 0, 8'h00);
        rst3 = 1'b0;
        apply(2, 0, 16'h0005, 1, 8'h00, 0);
        check_out(2, "rst_after", 1, 0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
